// File: rtl/cv32e40x_pkg.sv
// Shared CV32E40X coprocessor-interface types; only the result channel is needed here.
package cv32e40x_pkg;

  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_RFW_WIDTH = 32;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   float;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

endpackage

// File: rtl/xif_result_arbiter_pkg.sv
// Local types and index helpers for the XIF result arbiter.
package xif_result_arbiter_pkg;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } out_state_e;

  // Modular add for operands already below n (off <= n); avoids a divider.
  function automatic int unsigned rr_wrap(input int unsigned base, input int unsigned off,
                                          input int unsigned n);
    return (base + off >= n) ? base + off - n : base + off;
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return rr_wrap(idx, 1, n);
  endfunction

endpackage

// File: rtl/xif_rr_arbiter.sv
// Round-robin priority picker: first set request at or above ptr, wrapping to 0.
module xif_rr_arbiter
  import xif_result_arbiter_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && req[rr_wrap(32'(ptr), i, N)]) begin
        gnt[rr_wrap(32'(ptr), i, N)] = 1'b1;
        idx = IW'(rr_wrap(32'(ptr), i, N));
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xif_result_arbiter.sv
// Merges NUM_REQ coprocessor result streams into one registered result channel
// with round-robin fairness and full-throughput drain/load.
module xif_result_arbiter
  import cv32e40x_pkg::*;
  import xif_result_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFW_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  x_result_t [NUM_REQ-1:0]    req_result_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output x_result_t                  result_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
    $error("xif_result_arbiter: NUM_REQ must be in 2..8");
  end
  if (X_ID_WIDTH != cv32e40x_pkg::X_ID_WIDTH || X_RFW_WIDTH != cv32e40x_pkg::X_RFW_WIDTH)
  begin : g_width_check
    $error("xif_result_arbiter: widths must match cv32e40x_pkg");
  end

  out_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [NUM_REQ-1:0] win_gnt;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               load;

  xif_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (req_valid_i),
    .ptr (rr_ptr_q),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // Reset gates load so no source sees a handshake during a reset cycle.
  always_comb begin
    load = !rst_i && win_any && ((state_q == ST_EMPTY) || result_ready_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_FULL;
    end else if (state_q == ST_FULL && result_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    result_valid_o = (state_q == ST_FULL);
    req_ready_o    = load ? win_gnt : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o    <= '0;
      grant_idx_o <= '0;
      rr_ptr_q    <= '0;
    end else if (load) begin
      result_o    <= req_result_i[win_idx];
      grant_idx_o <= win_idx;
      rr_ptr_q    <= IDX_W'(rr_next(32'(win_idx), NUM_REQ));
    end
  end

endmodule
